manchester_rx_fifo: RTL and testbench

Parametrised Manchester receiver for the BEP decode datapath. It oversamples the serial `digital_in` line, decodes addressed frames of configurable width, and filters them by station address. Accepted payloads go into a small FIFO drained through a valid/ready port. It generalises the fixed 8-bit decoder with:

- configurable word and address width;
- configurable bit period;
- a broadcast address;
- buffering, error reporting and backpressure.

---
 rtl/manchester_rx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_manchester_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_rx_fifo.sv
// manchester_rx_fifo: oversampling Manchester receiver with address filter
// and a small payload FIFO drained through a valid/ready port.
//
// Parameters: DATA_WIDTH payload bits, ADDR_WIDTH address bits,
//   HALF_BIT_CYCLES half-bit period in clk cycles (even, >=4),
//   FIFO_DEPTH payload entries (power of two, >=2).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   digital_in       asynchronous Manchester line, idle low
//   halt             forces the decoder to IDLE, FIFO keeps draining
//   address          this station's address (all-ones is broadcast)
//   out_data/out_valid/out_ready  FIFO head, valid/ready handshake
//   frame_start      1-cycle pulse on start bit
//   frame_error      1-cycle pulse on framing (or parity) error
//   overflow         sticky, accepted frame dropped on full FIFO
//   busy             decoder not in IDLE
//   level            FIFO occupancy
// Build option: define MANCHESTER_RX_PARITY_EN to expect an even-parity
//   bit after the data bits, covering address+data.

module manchester_rx_fifo #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 4,
   parameter int HALF_BIT_CYCLES = 8,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          digital_in,
   input  logic                          halt,
   input  logic [ADDR_WIDTH-1:0]         address,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          frame_start,
   output logic                          frame_error,
   output logic                          overflow,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

`ifdef MANCHESTER_RX_PARITY_EN
   localparam int NB = ADDR_WIDTH + DATA_WIDTH + 1;
`else
   localparam int NB = ADDR_WIDTH + DATA_WIDTH;
`endif
   localparam int CW = $clog2(NB + 1);
   localparam int TW = $clog2(3 * HALF_BIT_CYCLES + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   localparam logic [TW-1:0] T_MIN = TW'(3 * HALF_BIT_CYCLES / 2);
   localparam logic [TW-1:0] T_MAX = TW'(5 * HALF_BIT_CYCLES / 2);
   localparam logic [TW-1:0] T_SAT = TW'(3 * HALF_BIT_CYCLES);
   localparam logic [CW-1:0] CNT_END = CW'(NB);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] BCAST = '1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RX   = 2'd1;
   localparam logic [1:0] S_TAIL = 2'd2;

   logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [1:0] state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NB-1:0] shreg_q, shreg_d;
   logic fs_q, fs_d, fe_q, fe_d, ovf_q, ovf_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] level_q, level_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic edge_det, rise, push, pop, full, push_ok, par_err;
   logic [ADDR_WIDTH-1:0] rx_addr;
   logic [DATA_WIDTH-1:0] rx_data;

   assign rx_addr = shreg_q[NB-1 -: ADDR_WIDTH];
   assign rx_data = shreg_q[NB-1-ADDR_WIDTH -: DATA_WIDTH];
`ifdef MANCHESTER_RX_PARITY_EN
   assign par_err = ^shreg_q;
`else
   assign par_err = 1'b0;
`endif

   always_comb begin
      sync1_d  = digital_in;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      edge_det = sync2_q ^ prev_q;
      rise     = sync2_q & ~prev_q;
      // timer_inc is the elapsed count including the current cycle,
      // so a nominal 2H edge spacing evaluates as exactly 2H.
      timer_inc = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
      state_d  = state_q;
      timer_d  = timer_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      fs_d     = 1'b0;
      fe_d     = 1'b0;
      push     = 1'b0;
      if (halt) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (rise) begin
                  state_d = S_RX;
                  timer_d = '0;
                  cnt_d   = '0;
                  fs_d    = 1'b1;
               end
            end
            S_RX: begin
               timer_d = timer_inc;
               if (cnt_q == CNT_END) begin
                  state_d = S_TAIL;
                  timer_d = '0;
                  if (par_err) begin
                     fe_d = 1'b1;
                  end else if (rx_addr == address || rx_addr == BCAST) begin
                     push = 1'b1;
                  end
               end else if (timer_inc > T_MAX) begin
                  state_d = S_TAIL;
                  timer_d = '0;
                  shreg_d = '0;
                  fe_d    = 1'b1;
               end else if (edge_det && timer_inc >= T_MIN) begin
                  shreg_d = {shreg_q[NB-2:0], sync2_q};
                  timer_d = '0;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
            S_TAIL: begin
               // reuse the timer as a consecutive-low-cycle counter
               timer_d = (edge_det || sync2_q) ? '0 : timer_inc;
               if (timer_q == T_SAT) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid = (level_q != '0);
      pop       = out_valid && out_ready;
      full      = (level_q == FULL_LVL);
      push_ok   = push && (!full || pop);
      ovf_d     = ovf_q | (push && full && !pop);
      wr_d      = push_ok ? wr_q + 1'b1 : wr_q;
      rd_d      = pop ? rd_q + 1'b1 : rd_q;
      level_d   = level_q;
      if (push_ok && !pop) level_d = level_q + 1'b1;
      if (!push_ok && pop) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         state_q <= S_IDLE;
         timer_q <= '0;
         cnt_q   <= '0;
         shreg_q <= '0;
         fs_q    <= 1'b0;
         fe_q    <= 1'b0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         fs_q    <= fs_d;
         fe_q    <= fe_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= rx_data;
   end

   assign out_data    = out_valid ? mem_q[rd_q] : '0;
   assign frame_start = fs_q;
   assign frame_error = fe_q;
   assign overflow    = ovf_q;
   assign busy        = (state_q != S_IDLE);
   assign level       = level_q;

endmodule

// File: tb/tb_manchester_rx_fifo.sv
// tb_manchester_rx_fifo: table-driven, directed and randomized checks of
// manchester_rx_fifo against a queue-based model of the accepted payloads.

module tb_manchester_rx_fifo;

   localparam int H = 8;
   localparam logic [3:0] MY_ADDR = 4'h5;
`ifdef MANCHESTER_RX_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif

   logic clk, rst, digital_in, halt, out_ready;
   logic [3:0] address;
   logic [7:0] out_data;
   logic out_valid, frame_start, frame_error, overflow, busy;
   logic [2:0] level;

   manchester_rx_fifo dut (
      .clk(clk), .rst(rst), .digital_in(digital_in), .halt(halt),
      .address(address), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .frame_start(frame_start),
      .frame_error(frame_error), .overflow(overflow), .busy(busy),
      .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int fs_cnt = 0;
   int fe_cnt = 0;
   bit jit_en = 0;
   bit ovf_exp = 0;
   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      if (frame_start) fs_cnt++;
      if (frame_error) fe_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
      bit         push;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int half();
      if (jit_en) return H - 2 + int'($urandom_range(0, 4));
      return H;
   endfunction

   task automatic model_push(input logic [3:0] a, input logic [7:0] d);
      if (a == MY_ADDR || a == 4'hF) begin
         if (exp_q.size() == 4) ovf_exp = 1;
         else exp_q.push_back(d);
      end
   endtask

   // mode 1: check frame_start/out_valid latency; mode 2: pop at push
   task automatic send_frame(input logic [3:0] a, input logic [7:0] d,
                             input int nbits, input int halt_at,
                             input int mode, input bit bad_par);
      logic [NB-1:0] bits;
`ifdef MANCHESTER_RX_PARITY_EN
      bits = {a, d, (^{a, d}) ^ bad_par};
`else
      bits = {a, d};
      if (bad_par) bits = {a, d};
`endif
      digital_in = 1'b0;
      repeat (H) @(negedge clk);
      digital_in = 1'b1;
      if (mode == 1) begin
         repeat (2) @(negedge clk);
         check("fs_early", 32'(frame_start), 0);
         @(negedge clk);
         check("fs_lat", 32'(frame_start), 1);
         repeat (half() - 3) @(negedge clk);
      end else begin
         repeat (half()) @(negedge clk);
      end
      for (int i = NB - 1; i >= NB - nbits; i--) begin
         if (i == halt_at) begin
            halt = 1'b1;
            @(negedge clk);
            check("halt_busy", 32'(busy), 0);
         end
         digital_in = ~bits[i];
         repeat (half()) @(negedge clk);
         digital_in = bits[i];
         if (i == 0 && mode != 0) begin
            repeat (3) @(negedge clk);
            if (mode == 1) check("valid_early", 32'(out_valid), 0);
            else out_ready = 1'b1;
            @(negedge clk);
            if (mode == 1) check("valid_lat", 32'(out_valid), 1);
            else out_ready = 1'b0;
            repeat (half() - 4) @(negedge clk);
         end else begin
            repeat (half()) @(negedge clk);
         end
      end
      if (nbits < NB) repeat (40) @(negedge clk);
      digital_in = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic drain();
      while (exp_q.size() > 0) begin
         check("drain_valid", 32'(out_valid), 1);
         check("drain_data", 32'(out_data), 32'(exp_q[0]));
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         void'(exp_q.pop_front());
      end
      check("drain_empty", 32'(out_valid), 0);
      check("drain_level", 32'(level), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      digital_in = 1'b0;
      halt = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_fs", 32'(frame_start), 0);
      check("rst_fe", 32'(frame_error), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_level", 32'(level), 0);
      rst = 1'b0;
      exp_q.delete();
      ovf_exp = 0;
      @(negedge clk);
   endtask

   initial begin
      int fs0, fe0, nf;
      logic [3:0] ra;
      logic [7:0] rd;
      address = MY_ADDR;
      tbl[0] = '{4'h5, 8'hA7, 1'b1};
      tbl[1] = '{4'h3, 8'h55, 1'b0};
      tbl[2] = '{4'hF, 8'h3C, 1'b1};
      tbl[3] = '{4'h5, 8'h00, 1'b1};
      tbl[4] = '{4'h6, 8'hFF, 1'b0};
      tbl[5] = '{4'h5, 8'hFF, 1'b1};
      do_reset();

      for (int i = 0; i < 6; i++) begin
         fs0 = fs_cnt;
         send_frame(tbl[i].a, tbl[i].d, NB, -1, (i == 0) ? 1 : 0, 0);
         check("tbl_start", 32'(fs_cnt - fs0), 1);
         check("tbl_busy", 32'(busy), 0);
         check("tbl_level", 32'(level), 32'(tbl[i].push));
         if (tbl[i].push) exp_q.push_back(tbl[i].d);
         drain();
      end

      do_reset();
      for (int k = 1; k <= 5; k++) begin
         send_frame(MY_ADDR, 8'(k), NB, -1, 0, 0);
         model_push(MY_ADDR, 8'(k));
      end
      check("ovf_level", 32'(level), 4);
      check("ovf_flag", 32'(overflow), 32'(ovf_exp));
      drain();

      do_reset();
      for (int k = 10; k <= 13; k++) begin
         send_frame(MY_ADDR, 8'(k), NB, -1, 0, 0);
         model_push(MY_ADDR, 8'(k));
      end
      send_frame(MY_ADDR, 8'd14, NB, -1, 2, 0);
      void'(exp_q.pop_front());
      model_push(MY_ADDR, 8'd14);
      check("fullpop_level", 32'(level), 4);
      check("fullpop_ovf", 32'(overflow), 0);
      drain();

      fs0 = fs_cnt;
      fe0 = fe_cnt;
      send_frame(MY_ADDR, 8'hC3, 6, -1, 0, 0);
      check("ferr_pulse", 32'(fe_cnt - fe0), 1);
      check("ferr_start", 32'(fs_cnt - fs0), 1);
      check("ferr_level", 32'(level), 0);
      send_frame(MY_ADDR, 8'h42, NB, -1, 0, 0);
      model_push(MY_ADDR, 8'h42);
      check("ferr_next", 32'(level), 1);
      drain();

      fe0 = fe_cnt;
      send_frame(MY_ADDR, 8'h99, NB, NB - 6, 0, 0);
      halt = 1'b0;
      repeat (4) @(negedge clk);
      check("halt_noerr", 32'(fe_cnt - fe0), 0);
      check("halt_level", 32'(level), 0);
      check("halt_idle", 32'(busy), 0);
      send_frame(4'hF, 8'h81, NB, -1, 0, 0);
      model_push(4'hF, 8'h81);
      check("halt_next", 32'(level), 1);
      drain();

`ifdef MANCHESTER_RX_PARITY_EN
      send_frame(MY_ADDR, 8'h5A, NB, -1, 0, 0);
      model_push(MY_ADDR, 8'h5A);
      check("par_ok", 32'(level), 1);
      drain();
      fe0 = fe_cnt;
      send_frame(MY_ADDR, 8'h5B, NB, -1, 0, 1);
      check("par_err", 32'(fe_cnt - fe0), 1);
      check("par_level", 32'(level), 0);
      check("par_ovf", 32'(overflow), 0);
`endif

      do_reset();
      jit_en = 1;
      for (int r = 0; r < 6; r++) begin
         nf = int'($urandom_range(1, 5));
         for (int f = 0; f < nf; f++) begin
            case ($urandom_range(0, 3))
               0: ra = MY_ADDR;
               1: ra = 4'hF;
               default: ra = 4'($urandom);
            endcase
            rd = 8'($urandom);
            send_frame(ra, rd, NB, -1, 0, 0);
            model_push(ra, rd);
         end
         check("rnd_level", 32'(level), 32'(exp_q.size()));
         check("rnd_ovf", 32'(overflow), 32'(ovf_exp));
         drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
